// File: rtl/phase_ctrl_if.sv
// Control/status bundle between the miniCPU phase sequencer and the datapath.
// PHASE_CTRL_INSTR_COUNT_EN adds the retired-instruction counter.
interface phase_ctrl_if;
   logic        start;
   logic        step_en;
   logic        halt_req;
   logic        mem_wait;
   logic [4:0]  phase;
   logic        running;
   logic        halted;
   logic        fault;
   logic        instr_done;
`ifdef PHASE_CTRL_INSTR_COUNT_EN
   logic [31:0] instr_count;
`endif

   // master: the environment driving control requests and observing phase
   modport master (
      output start, step_en, halt_req, mem_wait,
      input  phase, running, halted, fault, instr_done
`ifdef PHASE_CTRL_INSTR_COUNT_EN
      , input instr_count
`endif
   );

   // slave: the sequencer itself
   modport slave (
      input  start, step_en, halt_req, mem_wait,
      output phase, running, halted, fault, instr_done
`ifdef PHASE_CTRL_INSTR_COUNT_EN
      , output instr_count
`endif
   );
endinterface

// File: rtl/phase_ctrl.sv
// One-hot phase sequencer for the miniCPU: start, single-step, halt, memory stall
// and stall-timeout fault. PHASE_CTRL_INSTR_COUNT_EN adds a 32-bit instruction counter.
module phase_ctrl #(
   parameter int STALL_TIMEOUT  = 15,
   parameter bit START_ON_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   phase_ctrl_if.slave bus
);

   localparam int PH_F = 0;
   localparam int PH_D = 1;
   localparam int PH_E = 2;
   localparam int PH_M = 3;
   localparam int PH_W = 4;

   localparam logic [4:0] PHASE_F = 5'(1 << PH_F);
   localparam logic [4:0] PHASE_D = 5'(1 << PH_D);
   localparam logic [4:0] PHASE_E = 5'(1 << PH_E);
   localparam logic [4:0] PHASE_M = 5'(1 << PH_M);
   localparam logic [4:0] PHASE_W = 5'(1 << PH_W);

   localparam int CNT_W = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t           state_reg;
   logic [4:0]       phase_reg;
   logic             running_reg;
   logic             halted_reg;
   logic             fault_reg;
   logic             done_reg;
   logic             halt_pending_reg;
   logic [CNT_W-1:0] wait_cnt_reg;

   logic in_mem;
   logic enter_w;
   logic timeout_hit;

   assign in_mem  = (state_reg == RUN) && phase_reg[PH_M];
   assign enter_w = in_mem && !bus.mem_wait;

   // A zero timeout means the memory phase may stall forever.
   generate
      if (STALL_TIMEOUT == 0) begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end else begin : g_timeout
         assign timeout_hit = (wait_cnt_reg == CNT_LIMIT);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= START_ON_RESET ? RUN : IDLE;
         phase_reg        <= START_ON_RESET ? PHASE_F : 5'b0;
         running_reg      <= START_ON_RESET;
         halted_reg       <= 1'b0;
         fault_reg        <= 1'b0;
         done_reg         <= 1'b0;
         halt_pending_reg <= 1'b0;
         wait_cnt_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               phase_reg <= 5'b0;
               if (bus.start) begin
                  state_reg   <= RUN;
                  phase_reg   <= PHASE_F;
                  running_reg <= 1'b1;
               end
            end

            RUN: begin
               if (phase_reg[PH_F]) begin
                  phase_reg <= PHASE_D;
               end else if (phase_reg[PH_D]) begin
                  phase_reg <= PHASE_E;
               end else if (phase_reg[PH_E]) begin
                  if (bus.halt_req) begin
                     halt_pending_reg <= 1'b1;
                  end
                  phase_reg <= PHASE_M;
               end else if (phase_reg[PH_M]) begin
                  if (!bus.mem_wait) begin
                     phase_reg    <= PHASE_W;
                     done_reg     <= 1'b1;
                     wait_cnt_reg <= '0;
                  end else if (timeout_hit) begin
                     state_reg   <= FAULT;
                     phase_reg   <= 5'b0;
                     running_reg <= 1'b0;
                     fault_reg   <= 1'b1;
                  end else if (wait_cnt_reg != CNT_MAX) begin
                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  end
               end else if (phase_reg[PH_W]) begin
                  // Exit priority: halt beats single-step beats continue.
                  if (halt_pending_reg) begin
                     state_reg        <= HALT;
                     phase_reg        <= 5'b0;
                     running_reg      <= 1'b0;
                     halted_reg       <= 1'b1;
                     halt_pending_reg <= 1'b0;
                  end else if (bus.step_en) begin
                     state_reg   <= IDLE;
                     phase_reg   <= 5'b0;
                     running_reg <= 1'b0;
                  end else begin
                     phase_reg <= PHASE_F;
                  end
               end else begin
                  // Unreachable in normal operation; restart the rotation cleanly.
                  phase_reg <= PHASE_F;
               end
            end

            HALT: begin
               phase_reg  <= 5'b0;
               halted_reg <= 1'b1;
            end

            FAULT: begin
               phase_reg <= 5'b0;
               fault_reg <= 1'b1;
            end

            default: begin
               state_reg   <= IDLE;
               phase_reg   <= 5'b0;
               running_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.phase      = phase_reg;
   assign bus.running    = running_reg;
   assign bus.halted     = halted_reg;
   assign bus.fault      = fault_reg;
   assign bus.instr_done = done_reg;

`ifdef PHASE_CTRL_INSTR_COUNT_EN
   logic [31:0] instr_count_reg;

   // Counted on entry to writeback so the new value is visible during `w`.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count_reg <= 32'd0;
      end else if (enter_w) begin
         instr_count_reg <= instr_count_reg + 32'd1;
      end
   end

   assign bus.instr_count = instr_count_reg;
`endif

endmodule
